// File: rtl/gpio_stream_out.sv
// Buffered stream-to-GPIO emitter: circular word buffer feeding a pulse FSM with optional idle gap.
// Define GPIO_PARITY_EN to add the registered even-parity pin gpio_parity.
module gpio_stream_out #(
    parameter int data_width_g = 32,
    parameter int depth_g      = 8,
    parameter int gap_g        = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic [data_width_g-1:0]    in_data,
    output logic                       in_ready,
    output logic                       gpio_valid,
    output logic [data_width_g-1:0]    gpio_decrypted,
    output logic [$clog2(depth_g):0]   level,
    output logic                       overflow,
    input  logic                       clr_overflow
`ifdef GPIO_PARITY_EN
    ,
    output logic                       gpio_parity
`endif
);

    localparam int AW = $clog2(depth_g);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL     = LW'(depth_g);
    localparam logic [7:0]    GAP_LAST = 8'((gap_g == 0) ? 0 : gap_g - 1);

    typedef enum logic [1:0] {IDLE, EMIT, GAP} state_t;

    state_t                  state;
    logic [7:0]              gap_cnt;
    logic [AW-1:0]           wr_ptr, rd_ptr;
    logic [data_width_g-1:0] mem [depth_g];

    logic push, pop, drop, pop_slot;

    assign in_ready = (level != FULL);
    assign push     = in_valid && in_ready;
    assign drop     = in_valid && !in_ready;

    // Cycles where the FSM is free to start a new pulse; the last GAP cycle counts as one.
    always_comb begin
        pop_slot = 1'b0;
        case (state)
            IDLE:    pop_slot = 1'b1;
            EMIT:    pop_slot = (gap_g == 0);
            GAP:     pop_slot = (gap_cnt == GAP_LAST);
            default: pop_slot = 1'b0;
        endcase
        pop = pop_slot && (level != '0);
    end

    // Storage is not reset; pointers and level define what is valid.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= in_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            gap_cnt        <= '0;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            level          <= '0;
            overflow       <= 1'b0;
            gpio_valid     <= 1'b0;
            gpio_decrypted <= '0;
`ifdef GPIO_PARITY_EN
            gpio_parity    <= 1'b0;
`endif
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr         <= rd_ptr + 1'b1;
                gpio_decrypted <= mem[rd_ptr];
`ifdef GPIO_PARITY_EN
                gpio_parity    <= ^mem[rd_ptr];
`endif
            end
            gpio_valid <= pop;

            if (push && !pop)
                level <= level + 1'b1;
            else if (pop && !push)
                level <= level - 1'b1;

            if (drop)
                overflow <= 1'b1;
            else if (clr_overflow)
                overflow <= 1'b0;

            case (state)
                IDLE: begin
                    if (pop)
                        state <= EMIT;
                end
                EMIT: begin
                    if (gap_g > 0) begin
                        state   <= GAP;
                        gap_cnt <= '0;
                    end else begin
                        state <= pop ? EMIT : IDLE;
                    end
                end
                GAP: begin
                    if (gap_cnt == GAP_LAST)
                        state <= pop ? EMIT : IDLE;
                    else
                        gap_cnt <= gap_cnt + 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gpio_stream_out.sv
// Randomized and directed check of gpio_stream_out (gaps 0, 3, 255) against a queue-based reference.
module tb_gpio_stream_out;

    localparam int W  = 32;
    localparam int D  = 8;
    localparam int LW = 4;
    localparam int N  = 3;

    logic clk = 1'b0;
    logic rst, in_valid, clr_overflow;
    logic [W-1:0] in_data;
    logic [N-1:0] in_ready, gpio_valid, overflow;
    logic [N-1:0][W-1:0]  gpio_decrypted;
    logic [N-1:0][LW-1:0] level;
`ifdef GPIO_PARITY_EN
    logic [N-1:0] gpio_parity;
`endif

    always #5 clk = ~clk;

    gpio_stream_out #(.data_width_g(W), .depth_g(D), .gap_g(0)) u0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready[0]),
        .gpio_valid(gpio_valid[0]), .gpio_decrypted(gpio_decrypted[0]), .level(level[0]),
        .overflow(overflow[0]), .clr_overflow(clr_overflow)
`ifdef GPIO_PARITY_EN
        , .gpio_parity(gpio_parity[0])
`endif
    );
    gpio_stream_out #(.data_width_g(W), .depth_g(D), .gap_g(3)) u1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready[1]),
        .gpio_valid(gpio_valid[1]), .gpio_decrypted(gpio_decrypted[1]), .level(level[1]),
        .overflow(overflow[1]), .clr_overflow(clr_overflow)
`ifdef GPIO_PARITY_EN
        , .gpio_parity(gpio_parity[1])
`endif
    );
    gpio_stream_out #(.data_width_g(W), .depth_g(D), .gap_g(255)) u2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready[2]),
        .gpio_valid(gpio_valid[2]), .gpio_decrypted(gpio_decrypted[2]), .level(level[2]),
        .overflow(overflow[2]), .clr_overflow(clr_overflow)
`ifdef GPIO_PARITY_EN
        , .gpio_parity(gpio_parity[2])
`endif
    );

    // Reference: a word queue plus a cooldown of gap edges after every emitted word.
    logic [W-1:0] mq [N][$];
    int           cool  [N];
    logic         m_vld [N];
    logic [W-1:0] m_dat [N];
    logic         m_ovf [N];

    int vectors = 0;
    int miscompares = 0;

    function automatic int gap_of(int d);
        return (d == 0) ? 0 : (d == 1) ? 3 : 255;
    endfunction

    task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_step(int d);
        logic ready, drop;
        if (rst) begin
            mq[d].delete();
            cool[d]  = 0;
            m_vld[d] = 1'b0;
            m_dat[d] = '0;
            m_ovf[d] = 1'b0;
        end else begin
            ready = (mq[d].size() != D);
            drop  = in_valid && !ready;
            if (mq[d].size() > 0 && cool[d] == 0) begin
                m_vld[d] = 1'b1;
                m_dat[d] = mq[d].pop_front();
                cool[d]  = gap_of(d);
            end else begin
                m_vld[d] = 1'b0;
                if (cool[d] > 0) cool[d]--;
            end
            if (in_valid && ready) mq[d].push_back(in_data);
            if (drop) m_ovf[d] = 1'b1;
            else if (clr_overflow) m_ovf[d] = 1'b0;
        end
    endtask

    function automatic logic [63:0] exp_vec(int d);
        logic par;
        par = 1'b0;
`ifdef GPIO_PARITY_EN
        par = ^m_dat[d];
`endif
        return {24'd0, par, mq[d].size() != D, m_vld[d], m_ovf[d], LW'(mq[d].size()), m_dat[d]};
    endfunction

    function automatic logic [63:0] got_vec(int d);
        logic par;
        par = 1'b0;
`ifdef GPIO_PARITY_EN
        par = gpio_parity[d];
`endif
        return {24'd0, par, in_ready[d], gpio_valid[d], overflow[d], level[d], gpio_decrypted[d]};
    endfunction

    task automatic cyc();
        @(posedge clk);
        for (int d = 0; d < N; d++) model_step(d);
        @(negedge clk);
        for (int d = 0; d < N; d++) chk($sformatf("cycle_u%0d", d), got_vec(d), exp_vec(d));
    endtask

    task automatic idle(int n);
        in_valid = 1'b0;
        clr_overflow = 1'b0;
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic rst_pulse();
        in_valid = 1'b0;
        clr_overflow = 1'b0;
        rst = 1'b1;
        cyc();
        rst = 1'b0;
    endtask

    task automatic push(logic [W-1:0] v);
        in_valid = 1'b1;
        in_data  = v;
        cyc();
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; clr_overflow = 1'b0; in_data = '0;
        cyc(); cyc();
        rst = 1'b0;
        chk("reset_level", level[0], 0);
        chk("reset_ready", in_ready, 3'b111);
        chk("reset_valid", gpio_valid, 3'b000);

        // single word, 2-cycle latency
        push(32'hDEADBEEF);
        in_valid = 1'b0;
        cyc();
        chk("single_valid", gpio_valid[0], 1);
        chk("single_data", gpio_decrypted[0], 32'hDEADBEEF);
        cyc();
        chk("single_after", {gpio_valid[0], level[0]}, 0);

        // back-to-back with gap 0
        rst_pulse();
        push(32'h1);
        push(32'h2);
        chk("b2b_1", {gpio_valid[0], gpio_decrypted[0]}, {1'b1, 32'h1});
        push(32'h3);
        chk("b2b_2", {gpio_valid[0], gpio_decrypted[0]}, {1'b1, 32'h2});
        idle(1);
        chk("b2b_3", {gpio_valid[0], gpio_decrypted[0]}, {1'b1, 32'h3});
        idle(1);
        chk("b2b_end", {gpio_valid[0], gpio_decrypted[0]}, {1'b0, 32'h3});

        // gap 3: pulses 4 cycles apart, data holds in between
        rst_pulse();
        push(32'hA);
        push(32'hB);
        chk("gap_first", {gpio_valid[1], gpio_decrypted[1]}, {1'b1, 32'hA});
        in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk("gap_hold", {gpio_valid[1], gpio_decrypted[1]}, {1'b0, 32'hA});
        end
        cyc();
        chk("gap_second", {gpio_valid[1], gpio_decrypted[1]}, {1'b1, 32'hB});

        // overflow with gap 255
        rst_pulse();
        for (int i = 0; i < 9; i++) push(32'h100 + i);
        chk("ovf_full", {in_ready[2], level[2], overflow[2]}, {1'b0, 4'd8, 1'b0});
        push(32'h109);
        chk("ovf_set", {level[2], overflow[2]}, {4'd8, 1'b1});
        in_valid = 1'b0; clr_overflow = 1'b1;
        cyc();
        chk("ovf_clear", overflow[2], 0);
        in_valid = 1'b1;
        cyc();
        chk("ovf_drop_clr", overflow[2], 1);
        clr_overflow = 1'b0;

        // reset mid-operation
        rst_pulse();
        for (int i = 0; i < 6; i++) push(32'h200 + i);
        chk("mid_level", level[2], 5);
        rst_pulse();
        chk("mid_rst", {level[2], gpio_valid[2], gpio_decrypted[2]}, 0);
        idle(300);

`ifdef GPIO_PARITY_EN
        rst_pulse();
        push(32'h7);
        idle(1);
        chk("parity_7", gpio_parity[0], 1);
        push(32'h3);
        idle(1);
        chk("parity_3", gpio_parity[0], 0);
`endif

        // randomized traffic
        rst_pulse();
        for (int i = 0; i < 1500; i++) begin
            in_valid     = ($urandom % 3) != 0;
            in_data      = $urandom;
            clr_overflow = ($urandom % 16) == 0;
            rst          = ($urandom % 250) == 0;
            cyc();
        end
        rst = 1'b0;
        idle(20);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
